// File: rtl/console_uart_bridge_if.sv
// Data-memory bus bundle between the core (master) and the console UART bridge (slave).
interface console_uart_bridge_if;
    logic        enable;
    logic        state;
    logic [31:0] address;
    logic [3:0]  frame_mask;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        console_hit;

    modport master (
        output enable, state, address, frame_mask, write_data,
        input  read_data, console_hit
    );

    modport slave (
        input  enable, state, address, frame_mask, write_data,
        output read_data, console_hit
    );
endinterface

// File: rtl/console_uart_bridge.sv
// Memory-mapped console: buffers bytes written to TXDATA in a FIFO and sends them as 8N1 UART.
// STATUS reports FIFO occupancy, overflow (sticky), transmitter busy, empty and full.
module console_uart_bridge #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  reset,
    console_uart_bridge_if.slave  bus,
    output logic                  uart_tx
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [8:0]       count_q, count_d;
    logic             overflow_q;

    logic hit, tx_write, status_write, push, pop;
    logic empty, full, busy, bit_done;
    logic unused_bus;

    assign hit          = bus.enable && (bus.address[31:3] == BASE_ADDRESS[31:3]);
    assign tx_write     = hit && bus.state && !bus.address[2] && bus.frame_mask[3];
    assign status_write = hit && bus.state && bus.address[2];
    assign empty        = (count_q == 9'd0);
    assign full         = (count_q == 9'(FIFO_DEPTH));
    assign busy         = (state_q != StIdle);
    assign bit_done     = (baud_q == BaudW'(CLKS_PER_BIT - 1));
    // Full is judged before the edge, so a same-edge pop never frees a slot for the push.
    assign push         = tx_write && !full;

    assign bus.console_hit = hit;
    assign bus.read_data   = (hit && !bus.state && bus.address[2]) ?
                             {16'h0, count_q[7:0], 4'h0, overflow_q, busy, empty, full} : 32'h0;

    assign unused_bus = ^{bus.address[1:0], bus.frame_mask[2:0], bus.write_data[31:8]};

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 9'd1;
            2'b01:   count_d = count_q - 9'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle || bit_done) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + BaudW'(1);
            end
            if (state_q == StData && bit_done) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (pop) begin
                shift_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            if (tx_write && full) begin
                overflow_q <= 1'b1;
            end else if (status_write && bus.write_data[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.write_data[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = StStart;
            StStart: if (bit_done) state_d = StData;
            StData:  if (bit_done && bit_idx_q == 3'd7) state_d = StStop;
            StStop:  if (bit_done) state_d = empty ? StIdle : StStart;
            default: state_d = StIdle;
        endcase
    end

    // Popping at the end of STOP chains frames back-to-back with no idle gap.
    always_comb begin
        uart_tx = 1'b1;
        pop     = 1'b0;
        unique case (state_q)
            StIdle:  pop = !empty;
            StStart: uart_tx = 1'b0;
            StData:  uart_tx = shift_q[bit_idx_q];
            StStop:  pop = bit_done && !empty;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_console_uart_bridge.sv
// Randomized scoreboard bench for console_uart_bridge with a frame-timing reference model.
module tb_console_uart_bridge;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic reset;
    logic uart_tx;

    console_uart_bridge_if mem_if ();

    console_uart_bridge #(
        .BASE_ADDRESS (BASE),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (mem_if),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: bytes waiting, cycles left in the frame on the wire, byte on the wire.
    logic [7:0] mq [$];
    logic [7:0] sb [$];
    int         remaining;
    logic [7:0] cur;
    logic       ovf;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] status_model();
        return {16'h0, 8'(mq.size()), 4'h0, ovf, remaining != 0, mq.size() == 0,
                mq.size() == DEPTH};
    endfunction

    function automatic logic exp_tx();
        int b;
        if (remaining == 0) return 1'b1;
        b = (FRAME - remaining) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic hit, input logic wr, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] d);
        logic was_full, do_pop, txw;
        was_full = (mq.size() == DEPTH);
        do_pop   = (mq.size() > 0) && (remaining <= 1);
        txw      = hit && wr && !a[2] && m[3];
        if (txw && was_full) ovf = 1'b1;
        else if (hit && wr && a[2] && d[3]) ovf = 1'b0;
        if (do_pop) begin
            cur = mq.pop_front();
            remaining = FRAME;
        end else if (remaining > 0) begin
            remaining--;
        end
        if (txw && !was_full) begin
            mq.push_back(d[7:0]);
            sb.push_back(d[7:0]);
        end
    endtask

    task automatic access(input logic en, input logic wr, input logic [31:0] a,
                          input logic [3:0] m, input logic [31:0] d);
        logic hit;
        logic [31:0] exp_rd;
        mem_if.enable     = en;
        mem_if.state      = wr;
        mem_if.address    = a;
        mem_if.frame_mask = m;
        mem_if.write_data = d;
        #1;
        hit    = en && (a[31:3] == BASE[31:3]);
        exp_rd = (hit && !wr && a[2]) ? status_model() : 32'h0;
        check("console_hit", {31'h0, mem_if.console_hit}, {31'h0, hit});
        check("read_data", mem_if.read_data, exp_rd);
        @(posedge clk);
        model_edge(hit, wr, a, m, d);
        #2;
        check("uart_tx", {31'h0, uart_tx}, {31'h0, exp_tx()});
        @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        access(1'b1, 1'b1, BASE, 4'hF, {24'h0, b});
    endtask

    task automatic read_status();
        access(1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
    endtask

    task automatic do_reset();
        mem_if.enable = 1'b0;
        mem_if.state  = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        mq.delete();
        sb.delete();
        remaining = 0;
        ovf = 1'b0;
        #2;
        check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: UART receiver that checks every sampled cycle of each frame against the queue.
    logic [7:0] mon_exp, mon_rx;
    int         mon_k, mon_err;
    logic       mon_active;

    initial begin
        mon_active = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && uart_tx == 1'b0) begin
                    if (sb.size() == 0) begin
                        check("start_without_data", 32'(sb.size()), 32'd1);
                    end else begin
                        mon_exp    = sb.pop_front();
                        mon_active = 1'b1;
                        mon_k      = 0;
                        mon_err    = 0;
                        mon_rx     = 8'h0;
                    end
                end
                if (mon_active) begin
                    int b;
                    logic ebit;
                    b    = mon_k / CPB;
                    ebit = (b == 0) ? 1'b0 : (b <= 8) ? mon_exp[b-1] : 1'b1;
                    if (uart_tx !== ebit) mon_err++;
                    if (b >= 1 && b <= 8 && (mon_k % CPB) == CPB / 2) mon_rx[b-1] = uart_tx;
                    mon_k++;
                    if (mon_k == FRAME) begin
                        check("frame_byte", {24'h0, mon_rx}, {24'h0, mon_exp});
                        check("frame_shape_errs", 32'(mon_err), 32'd0);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] a, d;
        logic [3:0]  m;
        int          r;
        reset     = 1'b1;
        remaining = 0;
        ovf       = 1'b0;
        mem_if.enable     = 1'b0;
        mem_if.state      = 1'b0;
        mem_if.address    = 32'h0;
        mem_if.frame_mask = 4'h0;
        mem_if.write_data = 32'h0;
        @(negedge clk);
        do_reset();
        read_status();

        // Single frame, then idle status.
        write_tx(8'h41);
        repeat (42) read_status();

        // Back-to-back frames.
        write_tx(8'h55);
        write_tx(8'hAA);
        repeat (82) read_status();

        // Overflow from a burst, then clear it.
        for (int i = 0; i < 6; i++) write_tx(8'(8'h10 + i));
        read_status();
        access(1'b1, 1'b1, BASE + 32'h4, 4'hF, 32'h8);
        read_status();
        guard = 0;
        while ((remaining != 0 || mq.size() != 0) && guard < 1000) begin
            read_status();
            guard++;
        end

        // Masked-off byte lane does nothing.
        access(1'b1, 1'b1, BASE, 4'b0111, 32'h41);
        repeat (3) read_status();

        // Reset mid-frame.
        write_tx(8'hC3);
        repeat (13) access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        do_reset();
        read_status();
        repeat (3) access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // Outside the window.
        access(1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        access(1'b1, 1'b1, 32'h2000_0000, 4'hF, 32'h77);
        read_status();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 29);
            d = $urandom;
            m = 4'($urandom);
            if (r < 2) begin
                m[3] = (r == 0) ? 1'b1 : m[3];
                access(1'b1, 1'b1, BASE | 32'($urandom_range(0, 3)), m, d);
            end else if (r < 14) begin
                read_status();
            end else if (r == 14) begin
                access(1'b1, 1'b1, BASE + 32'h4, m, d);
            end else if (r == 15) begin
                access(1'b1, 1'b0, BASE, m, d);
            end else if (r < 19) begin
                a = $urandom;
                if (a[31:3] == BASE[31:3]) a = a ^ 32'h8000_0000;
                access(1'b1, r[0], a, m, d);
            end else begin
                access(1'b0, 1'($urandom), BASE, m, d);
            end
        end

        guard = 0;
        while ((remaining != 0 || mq.size() != 0) && guard < 2000) begin
            read_status();
            guard++;
        end
        check("drain_in_budget", {31'h0, guard < 2000}, 32'h1);
        repeat (4) read_status();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("monitor_idle", {31'h0, mon_active}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
